// File: rtl/float_to_dec.sv
// -----------------------------------------------------------------------------
// float_to_dec
//
// Iterative IEEE-754 single-precision to signed 32-bit integer converter.
// One operand is processed at a time. The significand is aligned by a
// one-bit-per-cycle shifter, the result is truncated toward zero and held
// until the consumer accepts it. Exception flags describe only the current
// result; they are not sticky.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   flt_value carries an operand this cycle
//   in_ready   block is idle and will accept an operand
//   flt_value  {sign, exp[7:0], mantissa[22:0]}
//   out_valid  int_value and the flags are valid
//   out_ready  consumer accepts the result
//   int_value  signed two's-complement result
//   overflow   operand out of int32 range or +/-Inf; result saturated
//   invalid    operand was NaN
//   inexact    nonzero fraction bits were discarded
// -----------------------------------------------------------------------------
module float_to_dec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] flt_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] int_value,
    output logic        overflow,
    output logic        invalid,
    output logic        inexact
);

    typedef enum logic [2:0] {
        IDLE,
        CLASSIFY,
        SHIFT,
        SIGN,
        DONE
    } state_t;

    // Operand class, resolved from the captured operand in CLASSIFY.
    typedef enum logic [2:0] {
        CLS_NAN,   // exp = 255, mantissa != 0
        CLS_INF,   // exp = 255, mantissa == 0
        CLS_TINY,  // |value| < 1: zero, denormal or E < 0
        CLS_SAT,   // beyond int32 range
        CLS_MIN,   // exactly -2^31
        CLS_NORM   // 0 <= E <= 30, needs alignment
    } cls_t;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // Exponent codes for E = 23 (no shift) and E = 31 (int32 boundary).
    localparam logic [7:0] EXP_NOSHIFT = 8'd150;
    localparam logic [7:0] EXP_BIAS    = 8'd127;
    localparam logic [7:0] EXP_LIMIT   = 8'd158;

    state_t      state;
    state_t      state_next;

    logic [31:0] op;          // captured operand
    logic [31:0] mag;         // magnitude being aligned, or preloaded result
    logic [4:0]  count;       // remaining shift steps
    logic        shift_left;  // alignment direction
    logic        special;     // result preloaded, skip negation
    logic        acc_ovf;
    logic        acc_inv;
    logic        acc_inx;     // inexact accumulator, fed by shifted-out bits

    logic        op_sign;
    logic [7:0]  op_exp;
    logic [22:0] op_man;

    assign op_sign = op[31];
    assign op_exp  = op[30:23];
    assign op_man  = op[22:0];

    // -------------------------------------------------------------------------
    // Classification of the captured operand and the values CLASSIFY loads.
    // -------------------------------------------------------------------------
    cls_t        cls;
    logic [31:0] pre_mag;
    logic [4:0]  pre_count;
    logic        pre_left;
    logic        pre_ovf;
    logic        pre_inv;
    logic        pre_inx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned and a latch is never inferred.
        cls       = CLS_NORM;
        pre_mag   = {8'b0, 1'b1, op_man};
        pre_count = '0;
        pre_left  = 1'b0;
        pre_ovf   = 1'b0;
        pre_inv   = 1'b0;
        pre_inx   = 1'b0;

        if (op_exp == 8'hFF) begin
            if (op_man != '0) begin
                cls     = CLS_NAN;
                pre_mag = INT_MIN;
                pre_inv = 1'b1;
            end else begin
                cls     = CLS_INF;
                pre_mag = op_sign ? INT_MIN : INT_MAX;
                pre_ovf = 1'b1;
            end
        end else if (op_exp < EXP_BIAS) begin
            // Zero is exact; a denormal or any normal with E < 0 loses bits.
            cls     = CLS_TINY;
            pre_mag = '0;
            pre_inx = (op_exp != '0) || (op_man != '0);
        end else if (op_exp > EXP_LIMIT ||
                     (op_exp == EXP_LIMIT && (!op_sign || op_man != '0))) begin
            cls     = CLS_SAT;
            pre_mag = op_sign ? INT_MIN : INT_MAX;
            pre_ovf = 1'b1;
        end else if (op_exp == EXP_LIMIT) begin
            // -2^31 is representable exactly and raises nothing.
            cls     = CLS_MIN;
            pre_mag = INT_MIN;
        end else begin
            // Here 127 <= exp <= 157, so |exp - 150| <= 23 fits in 5 bits.
            if (op_exp > EXP_NOSHIFT) begin
                pre_left  = 1'b1;
                pre_count = 5'(op_exp - EXP_NOSHIFT);
            end else begin
                pre_left  = 1'b0;
                pre_count = 5'(EXP_NOSHIFT - op_exp);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (in_valid) state_next = CLASSIFY;
            end
            CLASSIFY: begin
                if (cls == CLS_NORM && pre_count != '0) state_next = SHIFT;
                else                                    state_next = SIGN;
            end
            SHIFT: begin
                if (count == 5'd1) state_next = SIGN;
            end
            SIGN: begin
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op         <= '0;
            mag        <= '0;
            count      <= '0;
            shift_left <= 1'b0;
            special    <= 1'b0;
            acc_ovf    <= 1'b0;
            acc_inv    <= 1'b0;
            acc_inx    <= 1'b0;
            int_value  <= '0;
            overflow   <= 1'b0;
            invalid    <= 1'b0;
            inexact    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) op <= flt_value;
                end
                CLASSIFY: begin
                    // Accumulators restart here, so no flag leaks between
                    // operations.
                    mag        <= pre_mag;
                    count      <= pre_count;
                    shift_left <= pre_left;
                    special    <= (cls != CLS_NORM);
                    acc_ovf    <= pre_ovf;
                    acc_inv    <= pre_inv;
                    acc_inx    <= pre_inx;
                end
                SHIFT: begin
                    if (shift_left) begin
                        mag <= {mag[30:0], 1'b0};
                    end else begin
                        mag     <= {1'b0, mag[31:1]};
                        acc_inx <= acc_inx | mag[0];
                    end
                    count <= count - 5'd1;
                end
                SIGN: begin
                    // In range the magnitude is at most 2^31-1, so the
                    // negation cannot overflow.
                    if (!special && op_sign) int_value <= -mag;
                    else                     int_value <= mag;
                    overflow <= acc_ovf;
                    invalid  <= acc_inv;
                    inexact  <= acc_inx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/float_to_dec.md
# float_to_dec

Iterative IEEE-754 single-precision to signed 32-bit integer converter. It is the inverse of the integer-to-float front end in the logarithmic ALU datapath, and returns ALU results to integer form.
- One operand is accepted at a time through a valid/ready handshake.
- The significand is aligned with a one-bit-per-cycle shifter.
- The result is truncated toward zero and held until the consumer accepts it.
- Exceptions are reported with sticky-free per-result flags.

## Interface
- No parameters; widths are fixed at 32-bit float in, 32-bit two's-complement out.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  flt_value is valid this cycle.
- in_ready  output  1  block can accept an operand; equals (state == IDLE).
- flt_value  input  32  {sign, exp[7:0], mantissa[22:0]}.
- out_valid  output  1  int_value and the flags are valid.
- out_ready  input  1  consumer accepts the result.
- int_value  output  32  signed result.
- overflow  output  1  value is out of int32 range or is ±Inf; the result is saturated.
- invalid  output  1  operand was NaN.
- inexact  output  1  nonzero fraction bits were discarded.

## Operation
- States: IDLE, CLASSIFY, SHIFT, SIGN, DONE.
- Operand capture:
  - IDLE: when in_valid=1, the block captures flt_value and moves to CLASSIFY.
  - in_valid is ignored in every other state.
- CLASSIFY: unbiased exponent E = exp − 127. Cases are checked in this order:
  - exp=255, mantissa≠0 (NaN): result 0x80000000, invalid=1.
  - exp=255, mantissa=0 (±Inf): result 0x7FFFFFFF for +, 0x80000000 for −; overflow=1.
  - exp=0 (zero or denormal): result 0. inexact=1 if mantissa≠0.
  - E<0: result 0, inexact=1.
  - E>31, or E=31 with sign=0, or E=31 with mantissa≠0: saturate as for ±Inf, overflow=1.
  - E=31, sign=1, mantissa=0: result exactly 0x80000000, no flag.
  - Otherwise (0≤E≤30):
    - load magnitude = {8'b0, 1, mantissa}.
    - set count n = |E−23| and the shift direction: left if E>23, right if E<23.
    - go to SHIFT if n>0, else to SIGN.
  - All special cases go directly to SIGN with the result preloaded; no negation is applied to them.
- SHIFT:
  - Each cycle: shift the magnitude by one bit in the chosen direction and decrement count.
  - On a right shift, OR the bit shifted out into the inexact accumulator.
  - Leave for SIGN on the edge where count goes from 1 to 0.
- SIGN: if sign=1 and the case is in range, result = −magnitude (two's complement). Go to DONE.
- DONE:
  - out_valid=1; int_value and the flags are held stable.
  - When out_ready=1, return to IDLE and drop out_valid on that edge.
- Magnitude never exceeds 2^31−1 in range (E≤30), so negation cannot overflow.

## Timing
- Reset:
  - state=IDLE; int_value=0, out_valid=0, overflow=0, invalid=0, inexact=0, count=0.
  - in_ready=1 while in reset; in_valid is ignored until rst_n is released.
- Reset asserted in any state aborts the conversion immediately. Nothing is output for the aborted operand.
- Latency, counted from the accept edge (edge 0):
  - out_valid rises after edge 2+n, where n=|E−23| for in-range operands and n=0 for all special cases.
  - Minimum 2 cycles; maximum 25 cycles (E=0).
- No pipelining: in_ready=0 from the accept edge until the DONE→IDLE edge. The next accept can occur on the edge after that.
- The accept handshake and the result handshake can never coincide.
- If out_ready is held low, the block stays in DONE indefinitely with outputs unchanged.
- int_value and the flags are registered; they change only on the SIGN→DONE edge and on reset.
- Flags are cleared in CLASSIFY at the start of every operation.

## Test plan
- 0x40490FDB (3.14159):
  - int_value=0x00000003, inexact=1, other flags 0.
  - out_valid rises 24 cycles after accept (E=1, n=22).
- 0xC2F60000 (−123.0):
  - int_value=0xFFFFFF85, no flags, latency 19 (E=6, n=17).
- Width extremes:
  - 0x4B000001 → 0x00800001, latency 2.
  - 0x4EFFFFFF → 0x7FFFFF80, latency 9.
  - 0x00000000 → 0, no flags, latency 2.
- Saturation and exceptions, each at latency 2:
  - 0x4F000000 → 0x7FFFFFFF, overflow=1.
  - 0xCF000000 → 0x80000000, no flags.
  - 0xFF800000 → 0x80000000, overflow=1.
  - 0x7FC00000 → 0x80000000, invalid=1.
  - 0x3F000000 → 0, inexact=1.
- Handshake:
  - Hold out_ready=0 for 10 cycles after out_valid: outputs stable, in_ready=0.
  - A new in_valid during that window is ignored.
  - Raise out_ready: back to IDLE, and the next operand is accepted the cycle after.
- Reset:
  - Assert rst_n=0 mid-SHIFT on 0x3F800000: all outputs 0 immediately, no stale out_valid after release.
  - A following 0x41200000 converts to 0x0000000A.
